// File: rtl/tlb_pkg.sv
// Shared types and default widths for the TLB translator and its replacement logic.
package tlb_pkg;

    localparam int DEF_TLB_ENTRIES = 4;
    localparam int DEF_VPN_W       = 6;
    localparam int DEF_PPN_W       = 2;
    localparam int DEF_OFFSET_W    = 8;
    localparam int DEF_AGE_W       = $clog2(DEF_TLB_ENTRIES);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WALK,
        ISSUE,
        FAULT
    } tlb_state_t;

    typedef struct packed {
        logic                 valid;
        logic [DEF_VPN_W-1:0] tag;
        logic [DEF_PPN_W-1:0] ppn;
        logic [DEF_AGE_W-1:0] age;
    } tlb_entry_t;

endpackage

// File: rtl/tlb_translator_lru.sv
// Age-based LRU bookkeeping: ages form a permutation; the oldest entry (or the
// lowest-index invalid one) is the fill victim.
module tlb_lru #(
    parameter int ENTRIES = 4,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_touch,
    input  logic [IDX_W-1:0]   i_touch_idx,
    input  logic [ENTRIES-1:0] i_valid,
    output logic [IDX_W-1:0]   o_victim_idx
);

    logic [IDX_W-1:0] r_age [ENTRIES];
    logic [IDX_W-1:0] w_touch_age;
    logic [IDX_W-1:0] w_victim;

    assign w_touch_age  = r_age[i_touch_idx];
    assign o_victim_idx = w_victim;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_age[i] <= IDX_W'(i);
            end
        end else if (i_touch) begin
            // Touched entry becomes youngest; only entries younger than it age.
            for (int i = 0; i < ENTRIES; i++) begin
                if (i_touch_idx == IDX_W'(i)) begin
                    r_age[i] <= '0;
                end else if (r_age[i] < w_touch_age) begin
                    r_age[i] <= r_age[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_victim = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (r_age[i] == IDX_W'(ENTRIES - 1)) begin
                w_victim = IDX_W'(i);
            end
        end
        // Invalid entries take precedence; the descending scan leaves the lowest index.
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!i_valid[i]) begin
                w_victim = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/tlb_translator.sv
// Fully associative TLB front-end: translates CPU accesses, walks the page table
// on a miss, and issues physical requests to the cache. Macro TLB_STATS_EN adds hit/miss counters.
module tlb_translator
    import tlb_pkg::*;
#(
    parameter int TLB_ENTRIES = DEF_TLB_ENTRIES,
    parameter int VPN_W       = DEF_VPN_W,
    parameter int PPN_W       = DEF_PPN_W,
    parameter int OFFSET_W    = DEF_OFFSET_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cpu_req,
    input  logic                      cpu_write,
    input  logic [VPN_W+OFFSET_W-1:0] cpu_vaddr,
    input  logic [31:0]               cpu_write_data,
    input  logic                      tlb_flush,
    output logic                      busy,
    output logic                      cache_en,
    output logic                      cache_write,
    output logic [PPN_W+OFFSET_W-1:0] cache_address,
    output logic [31:0]               cache_write_data,
    output logic                      pt_req,
    output logic [VPN_W-1:0]          pt_vpn,
    input  logic                      pt_ack,
    input  logic                      pt_valid,
    input  logic [PPN_W-1:0]          pt_ppn,
    output logic                      page_fault
`ifdef TLB_STATS_EN
    ,
    output logic [15:0]               hit_count,
    output logic [15:0]               miss_count
`endif
);

    localparam int IDX_W = $clog2(TLB_ENTRIES);

    tlb_state_t                  r_state;
    logic                        r_write;
    logic [VPN_W+OFFSET_W-1:0]   r_vaddr;
    logic [31:0]                 r_wdata;
    logic [PPN_W-1:0]            r_issue_ppn;

    logic [TLB_ENTRIES-1:0]      r_valid;
    logic [VPN_W-1:0]            r_tag [TLB_ENTRIES];
    logic [PPN_W-1:0]            r_ppn [TLB_ENTRIES];

    logic [VPN_W-1:0]            w_vpn;
    logic [OFFSET_W-1:0]         w_offset;
    logic [TLB_ENTRIES-1:0]      w_hit_vec;
    logic                        w_hit;
    logic [IDX_W-1:0]            w_hit_idx;
    logic [IDX_W-1:0]            w_victim;
    logic                        w_fill;
    logic                        w_touch;
    logic [IDX_W-1:0]            w_touch_idx;
    logic                        w_issue;
    logic                        w_walk;

    assign w_vpn    = r_vaddr[VPN_W+OFFSET_W-1:OFFSET_W];
    assign w_offset = r_vaddr[OFFSET_W-1:0];

    generate
        for (genvar gi = 0; gi < TLB_ENTRIES; gi++) begin : g_cmp
            assign w_hit_vec[gi] = r_valid[gi] && (r_tag[gi] == w_vpn);
        end
    endgenerate

    assign w_hit = |w_hit_vec;

    always_comb begin
        w_hit_idx = '0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (w_hit_vec[i]) begin
                w_hit_idx = IDX_W'(i);
            end
        end
    end

    // A flush in the same cycle as a successful walk suppresses the fill.
    assign w_fill      = (r_state == WALK) && pt_ack && pt_valid && !tlb_flush && !rst;
    assign w_touch     = w_fill || ((r_state == LOOKUP) && w_hit);
    assign w_touch_idx = w_fill ? w_victim : w_hit_idx;

    tlb_lru #(
        .ENTRIES (TLB_ENTRIES),
        .IDX_W   (IDX_W)
    ) u_lru (
        .clk          (clk),
        .rst          (rst),
        .i_touch      (w_touch),
        .i_touch_idx  (w_touch_idx),
        .i_valid      (r_valid),
        .o_victim_idx (w_victim)
    );

    always_ff @(posedge clk) begin
        if (rst || tlb_flush) begin
            r_valid <= '0;
        end else if (w_fill) begin
            r_valid[w_victim] <= 1'b1;
        end
        if (w_fill) begin
            r_tag[w_victim] <= w_vpn;
            r_ppn[w_victim] <= pt_ppn;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_write     <= 1'b0;
            r_vaddr     <= '0;
            r_wdata     <= '0;
            r_issue_ppn <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cpu_req) begin
                        r_write <= cpu_write;
                        r_vaddr <= cpu_vaddr;
                        r_wdata <= cpu_write_data;
                        r_state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (w_hit) begin
                        r_issue_ppn <= r_ppn[w_hit_idx];
                        r_state     <= ISSUE;
                    end else begin
                        r_state <= WALK;
                    end
                end
                WALK: begin
                    if (pt_ack) begin
                        r_state <= pt_valid ? LOOKUP : FAULT;
                    end
                end
                ISSUE:   r_state <= IDLE;
                FAULT:   r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Outputs decode from state and captured registers only; rst forces them low immediately.
    assign w_issue          = (r_state == ISSUE) && !rst;
    assign w_walk           = (r_state == WALK) && !rst;
    assign busy             = (r_state != IDLE) && !rst;
    assign cache_en         = w_issue;
    assign cache_write      = w_issue && r_write;
    assign cache_address    = w_issue ? {r_issue_ppn, w_offset} : '0;
    assign cache_write_data = w_issue ? r_wdata : '0;
    assign pt_req           = w_walk;
    assign pt_vpn           = w_walk ? w_vpn : '0;
    assign page_fault       = (r_state == FAULT) && !rst;

`ifdef TLB_STATS_EN
    logic [15:0] r_hit_count;
    logic [15:0] r_miss_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (r_state == LOOKUP) begin
            if (w_hit) begin
                if (r_hit_count != 16'hFFFF) begin
                    r_hit_count <= r_hit_count + 16'd1;
                end
            end else if (r_miss_count != 16'hFFFF) begin
                r_miss_count <= r_miss_count + 16'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_tlb_translator.sv
// Directed bench for tlb_translator: vector table for translate/replace/fault,
// hand sequences for flush-vs-fill and reset mid-walk. Stats checks with TLB_STATS_EN.
module tb_tlb_translator;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_write;
    logic [13:0] cpu_vaddr;
    logic [31:0] cpu_write_data;
    logic        tlb_flush;
    logic        busy;
    logic        cache_en;
    logic        cache_write;
    logic [9:0]  cache_address;
    logic [31:0] cache_write_data;
    logic        pt_req;
    logic [5:0]  pt_vpn;
    logic        pt_ack;
    logic        pt_valid;
    logic [1:0]  pt_ppn;
    logic        page_fault;
`ifdef TLB_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tlb_translator dut (
        .clk              (clk),
        .rst              (rst),
        .cpu_req          (cpu_req),
        .cpu_write        (cpu_write),
        .cpu_vaddr        (cpu_vaddr),
        .cpu_write_data   (cpu_write_data),
        .tlb_flush        (tlb_flush),
        .busy             (busy),
        .cache_en         (cache_en),
        .cache_write      (cache_write),
        .cache_address    (cache_address),
        .cache_write_data (cache_write_data),
        .pt_req           (pt_req),
        .pt_vpn           (pt_vpn),
        .pt_ack           (pt_ack),
        .pt_valid         (pt_valid),
        .pt_ppn           (pt_ppn),
        .page_fault       (page_fault)
`ifdef TLB_STATS_EN
        ,
        .hit_count        (hit_count),
        .miss_count       (miss_count)
`endif
    );

    typedef struct {
        logic        write;
        logic [13:0] vaddr;
        logic [31:0] wdata;
        int          exp_walks;
        logic        exp_en;
        logic [9:0]  exp_addr;
        logic        exp_fault;
        int          exp_lat;
    } vec_t;

    vec_t vecs [11];

    // Page table: VPN 9 unmapped, otherwise PPN = VPN + 1 (mod 4).
    function automatic logic model_valid(input logic [5:0] vpn);
        return vpn != 6'd9;
    endfunction

    function automatic logic [1:0] model_ppn(input logic [5:0] vpn);
        logic [1:0] low;
        low = vpn[1:0];
        return low + 2'd1;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_req(input logic wr, input logic [13:0] va, input logic [31:0] wd);
        cpu_req        = 1'b1;
        cpu_write      = wr;
        cpu_vaddr      = va;
        cpu_write_data = wd;
        tick();
        cpu_req        = 1'b0;
        cpu_write      = 1'b0;
        cpu_vaddr      = '0;
        cpu_write_data = '0;
    endtask

    // Runs from the cycle after the request edge until busy drops, acting as page table.
    task automatic run(output int walks, output int en_cnt, output int faults,
                       output int lat, output int fault_cyc, output int done_cyc,
                       output logic [9:0] addr, output logic wr, output logic [31:0] wd,
                       output logic [5:0] walk_vpn, output logic timeout);
        int cyc;
        walks = 0; en_cnt = 0; faults = 0; lat = 0; fault_cyc = 0;
        addr = '0; wr = 1'b0; wd = '0; walk_vpn = '0;
        cyc = 1;
        while (busy && cyc < 40) begin
            if (cache_en) begin
                en_cnt++;
                lat  = cyc;
                addr = cache_address;
                wr   = cache_write;
                wd   = cache_write_data;
            end
            if (page_fault) begin
                faults++;
                fault_cyc = cyc;
            end
            if (pt_req) begin
                walks++;
                walk_vpn = pt_vpn;
                pt_ack   = 1'b1;
                pt_valid = model_valid(pt_vpn);
                pt_ppn   = model_ppn(pt_vpn);
            end
            tick();
            pt_ack   = 1'b0;
            pt_valid = 1'b0;
            pt_ppn   = '0;
            cyc++;
        end
        done_cyc = cyc;
        timeout  = busy;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ctl"}, {59'd0, busy, cache_en, cache_write, pt_req, page_fault}, 64'd0);
        check({tag, "_addr"}, {54'd0, cache_address}, 64'd0);
        check({tag, "_wdata"}, {32'd0, cache_write_data}, 64'd0);
        check({tag, "_ptvpn"}, {58'd0, pt_vpn}, 64'd0);
    endtask

    initial begin
        int          walks, en_cnt, faults, lat, fault_cyc, done_cyc;
        logic [9:0]  addr;
        logic        wr, tmo;
        logic [31:0] wd;
        logic [5:0]  wvpn;
        logic [5:0]  exp_vpn;

        vecs[0]  = '{1'b0, 14'h0123, 32'h0000_0000, 1, 1'b1, 10'h223, 1'b0, 4};
        vecs[1]  = '{1'b0, 14'h0145, 32'h0000_0000, 0, 1'b1, 10'h245, 1'b0, 2};
        vecs[2]  = '{1'b1, 14'h02AA, 32'hDEAD_BEEF, 1, 1'b1, 10'h3AA, 1'b0, 4};
        vecs[3]  = '{1'b0, 14'h0310, 32'h0000_0000, 1, 1'b1, 10'h010, 1'b0, 4};
        vecs[4]  = '{1'b0, 14'h0401, 32'h0000_0000, 1, 1'b1, 10'h101, 1'b0, 4};
        vecs[5]  = '{1'b0, 14'h01FF, 32'h0000_0000, 0, 1'b1, 10'h2FF, 1'b0, 2};
        vecs[6]  = '{1'b0, 14'h0507, 32'h0000_0000, 1, 1'b1, 10'h207, 1'b0, 4};
        vecs[7]  = '{1'b0, 14'h0100, 32'h0000_0000, 0, 1'b1, 10'h200, 1'b0, 2};
        vecs[8]  = '{1'b0, 14'h0220, 32'h0000_0000, 1, 1'b1, 10'h320, 1'b0, 4};
        vecs[9]  = '{1'b0, 14'h0905, 32'h0000_0000, 1, 1'b0, 10'h000, 1'b1, 0};
        vecs[10] = '{1'b1, 14'h0433, 32'h1234_5678, 0, 1'b1, 10'h133, 1'b0, 2};

        rst = 1'b1; cpu_req = 1'b0; cpu_write = 1'b0; cpu_vaddr = '0;
        cpu_write_data = '0; tlb_flush = 1'b0; pt_ack = 1'b0; pt_valid = 1'b0; pt_ppn = '0;
        tick();
        tick();
        check_quiet("reset");
        rst = 1'b0;
        tick();

        for (int v = 0; v < 11; v++) begin
            issue_req(vecs[v].write, vecs[v].vaddr, vecs[v].wdata);
            run(walks, en_cnt, faults, lat, fault_cyc, done_cyc, addr, wr, wd, wvpn, tmo);
            $display("vec %0d vaddr=%h walks=%0d en=%0d addr=%h wr=%0d fault=%0d lat=%0d",
                     v, vecs[v].vaddr, walks, en_cnt, addr, wr, faults, lat);
            check("timeout", {63'd0, tmo}, 64'd0);
            check("walks", walks, vecs[v].exp_walks);
            check("cache_en_count", en_cnt, {63'd0, vecs[v].exp_en});
            check("fault_count", faults, {63'd0, vecs[v].exp_fault});
            if (vecs[v].exp_en) begin
                check("cache_address", {54'd0, addr}, {54'd0, vecs[v].exp_addr});
                check("cache_write", {63'd0, wr}, {63'd0, vecs[v].write});
                check("cache_write_data", {32'd0, wd}, {32'd0, vecs[v].wdata});
                check("latency", lat, vecs[v].exp_lat);
            end
            if (vecs[v].exp_walks > 0) begin
                exp_vpn = vecs[v].vaddr[13:8];
                check("pt_vpn", {58'd0, wvpn}, {58'd0, exp_vpn});
            end
            if (vecs[v].exp_fault) begin
                check("busy_drop_after_fault", done_cyc, fault_cyc + 1);
            end
            tick();
        end

        // Flush coinciding with the walk acknowledge must discard the fill.
        issue_req(1'b0, 14'h0611, 32'h0);
        tick();
        check("flush_walk1_req", {63'd0, pt_req}, 64'd1);
        check("flush_walk1_vpn", {58'd0, pt_vpn}, 64'd6);
        pt_ack = 1'b1; pt_valid = 1'b1; pt_ppn = 2'd3; tlb_flush = 1'b1;
        tick();
        pt_ack = 1'b0; pt_valid = 1'b0; pt_ppn = '0; tlb_flush = 1'b0;
        run(walks, en_cnt, faults, lat, fault_cyc, done_cyc, addr, wr, wd, wvpn, tmo);
        $display("flush seq walks=%0d en=%0d addr=%h", walks, en_cnt, addr);
        check("flush_timeout", {63'd0, tmo}, 64'd0);
        check("flush_second_walk", walks, 1);
        check("flush_cache_en", en_cnt, 1);
        check("flush_cache_address", {54'd0, addr}, 64'h311);
        tick();

        // Flush also dropped earlier entries: VPN 1 must walk again.
        issue_req(1'b0, 14'h0150, 32'h0);
        run(walks, en_cnt, faults, lat, fault_cyc, done_cyc, addr, wr, wd, wvpn, tmo);
        $display("post-flush vpn1 walks=%0d addr=%h", walks, addr);
        check("postflush_walks", walks, 1);
        check("postflush_address", {54'd0, addr}, 64'h250);
        tick();

        // Reset during a walk, then a late acknowledge.
        issue_req(1'b0, 14'h0700, 32'h0);
        tick();
        check("rstwalk_pt_req", {63'd0, pt_req}, 64'd1);
        rst = 1'b1;
        #1;
        check("rstwalk_busy_in_rst", {62'd0, busy, pt_req}, 64'd0);
        tick();
        rst = 1'b0;
        pt_ack = 1'b1; pt_valid = 1'b1; pt_ppn = 2'd0;
        tick();
        pt_ack = 1'b0; pt_valid = 1'b0;
        $display("reset-during-walk busy=%0d pt_req=%0d", busy, pt_req);
        check_quiet("late_ack");
        tick();
        check_quiet("late_ack2");
        issue_req(1'b0, 14'h0704, 32'h0);
        run(walks, en_cnt, faults, lat, fault_cyc, done_cyc, addr, wr, wd, wvpn, tmo);
        $display("vpn7 after reset walks=%0d addr=%h", walks, addr);
        check("late_ack_no_fill", walks, 1);
        check("vpn7_address", {54'd0, addr}, 64'h004);
        tick();

`ifdef TLB_STATS_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("stats_reset", {32'd0, hit_count, miss_count}, 64'd0);
        issue_req(1'b0, 14'h0123, 32'h0);
        run(walks, en_cnt, faults, lat, fault_cyc, done_cyc, addr, wr, wd, wvpn, tmo);
        issue_req(1'b0, 14'h0210, 32'h0);
        run(walks, en_cnt, faults, lat, fault_cyc, done_cyc, addr, wr, wd, wvpn, tmo);
        issue_req(1'b0, 14'h0145, 32'h0);
        run(walks, en_cnt, faults, lat, fault_cyc, done_cyc, addr, wr, wd, wvpn, tmo);
        $display("stats hit=%0d miss=%0d", hit_count, miss_count);
        check("hit_count", {48'd0, hit_count}, 64'd3);
        check("miss_count", {48'd0, miss_count}, 64'd2);
        tlb_flush = 1'b1;
        tick();
        tlb_flush = 1'b0;
        check("stats_after_flush", {32'd0, hit_count, miss_count}, {32'd0, 16'd3, 16'd2});
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tlb_translator.md
TLB_TRANSLATOR -- requirements
Module: tlb_translator

Interface
REQ-001 SHALL have parameter TLB_ENTRIES, default 4, number of fully associative entries.
REQ-002 SHALL have parameter VPN_W, default 6, virtual page number width.
REQ-003 SHALL have parameter PPN_W, default 2, physical page number width.
REQ-004 SHALL have parameter OFFSET_W, default 8, page offset width (256-byte pages).
REQ-005 SHALL use a single clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-006 cpu_req input 1 access request; cpu_write input 1 write access; cpu_vaddr input VPN_W+OFFSET_W virtual address; cpu_write_data input 32 store data.
REQ-007 tlb_flush input 1 invalidate all entries.
REQ-008 busy output 1 request in progress.
REQ-009 cache_en output 1 one-cycle issue strobe to cache; cache_write output 1; cache_address output PPN_W+OFFSET_W physical address; cache_write_data output 32.
REQ-010 pt_req output 1 page-table walk request; pt_vpn output VPN_W; pt_ack input 1 walk done; pt_valid input 1 mapping present; pt_ppn input PPN_W.
REQ-011 page_fault output 1 one-cycle fault strobe.

Function
REQ-012 SHALL implement FSM states IDLE, LOOKUP, WALK, ISSUE, FAULT; busy=1 in any state except IDLE.
REQ-013 IDLE: cpu_req=1 SHALL capture cpu_write, cpu_vaddr, cpu_write_data and go to LOOKUP; cpu_req is ignored while busy.
REQ-014 LOOKUP: a hit is an entry with valid=1 and tag==captured VPN; hit SHALL go to ISSUE, miss SHALL go to WALK.
REQ-015 ISSUE SHALL last one cycle with cache_en=1, cache_address={ppn,offset}, cache_write/cache_write_data from the captured request, then return to IDLE; hit latency is req cycle + 2 to cache_en.
REQ-016 WALK SHALL hold pt_req=1 with pt_vpn=captured VPN until the cycle pt_ack=1.
REQ-017 On pt_ack with pt_valid=1, SHALL write {valid=1, tag, ppn} into the victim entry and go to LOOKUP, so the retry hits.
REQ-018 On pt_ack with pt_valid=0, SHALL go to FAULT, pulse page_fault for one cycle, issue nothing to cache, and return to IDLE.
REQ-019 Victim SHALL be the lowest-index invalid entry, else the entry with age == TLB_ENTRIES-1.
REQ-020 Each entry SHALL have an age counter of width $clog2(TLB_ENTRIES). On a hit or fill, the touched entry age SHALL become 0 and entries with a smaller age SHALL increment. Ages SHALL stay a permutation of 0..TLB_ENTRIES-1.
REQ-021 tlb_flush SHALL clear every valid bit at the next edge in any state; FSM state is unaffected.
REQ-022 If tlb_flush and a fill coincide, flush SHALL win: no entry is written, and the retried LOOKUP misses and walks again.
REQ-023 All outputs SHALL be registered or decoded from state only; no combinational path from cpu_* to cache_* or pt_*.

Reset
REQ-024 rst SHALL force IDLE, clear all valid bits, and set ages to 0..TLB_ENTRIES-1 by index.
REQ-025 While rst is asserted, busy, cache_en, cache_write, pt_req and page_fault SHALL be 0, and cache_address, cache_write_data and pt_vpn SHALL be 0.
REQ-026 rst during WALK SHALL abandon the walk; a late pt_ack SHALL be ignored.

Configuration
REQ-027 With TLB_STATS_EN defined, SHALL add outputs hit_count[15:0] and miss_count[15:0]; these count LOOKUP hits and misses (a retry after fill counts as a hit), saturate at 16'hFFFF, are cleared by rst, and are not cleared by tlb_flush.
REQ-028 Without TLB_STATS_EN, these ports and counters SHALL not exist.

Structure
REQ-029 Shared package tlb_pkg SHALL hold the state enum, the entry struct {valid, tag, ppn, age} and default widths.
REQ-030 One sub-module, tlb_lru, SHALL hold the age update and victim select; the lookup compare stays in tlb_translator.

Verification
REQ-031 Cold read vaddr 14'h0123 with PT mapping VPN 1 -> PPN 2 -> one walk, then cache_en with cache_address 10'h223, cache_write=0.
REQ-032 Repeat read of 14'h0145 -> no pt_req; cache_en exactly 2 cycles after cpu_req; cache_address 10'h245.
REQ-033 Fill VPNs 1,2,3,4, touch VPN 1, then access VPN 5 -> VPN 2's entry is replaced; a later VPN 1 access hits.
REQ-034 pt_valid=0 for VPN 9 -> one page_fault pulse, no cache_en, busy drops the next cycle.
REQ-035 tlb_flush asserted in the same cycle as pt_ack -> second walk for the same VPN; asserting rst during WALK followed by a late pt_ack -> stays IDLE with all outputs 0.
REQ-036 With TLB_STATS_EN, 3 hits and 2 misses -> hit_count=3, miss_count=2, counting the retry hits after each fill.
